// File: rtl/rmst_strided_tile_loader.sv
`default_nettype none
// ============================================================================
// rmst_strided_tile_loader : strided 2-D tile fetch through the Avalon read
// master, credit-throttled bursts, XDW->DW unpack into a downstream FIFO.
// Revision: 1.0
// ============================================================================
module rmst_strided_tile_loader #(
  parameter int DW          = 32,
  parameter int XDW         = 128,
  parameter int XAW         = 32,
  parameter int CW          = 16,
  parameter int BLEN        = 8,
  parameter int RFIFO_BEATS = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [XAW-1:0] cfg_base_addr,
  input  logic [CW-1:0]  cfg_row_words,
  input  logic [CW-1:0]  cfg_rows,
  input  logic [XAW-1:0] cfg_row_stride,
  input  logic           load_start,
  output logic           load_busy,
  output logic           load_done,
  output logic           rmst_fixed_location,
  output logic [XAW-1:0] rmst_read_base,
  output logic [XAW-1:0] rmst_read_length,
  output logic           rmst_go,
  input  logic           rmst_done,
  output logic           rmst_user_read_buffer,
  input  logic [XDW-1:0] rmst_user_buffer_data,
  input  logic           rmst_user_data_available,
  output logic [DW-1:0]  out_data,
  output logic           out_push,
  input  logic           out_almost_full
);

  localparam int c_wcnt     = XDW / DW;
  localparam int c_log_wcnt = $clog2(c_wcnt);
  localparam int c_bpw      = DW / 8;
  localparam int c_crw      = $clog2(RFIFO_BEATS + BLEN + 1) + 1;
  localparam int c_wvw      = $clog2(c_wcnt + 1);
  localparam int c_tw       = 2 * CW;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_MST = 3'd2,
    S_FLUSH    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [XAW-1:0]     r_row_addr, r_burst_addr, r_stride;
  logic [CW-1:0]      r_rows_left, r_words_left, r_row_words;
  logic [c_tw-1:0]    r_total, r_popped, r_pushed;
  logic [c_crw-1:0]   r_credits;
  logic               r_skip;
  logic [XDW-1:0]     r_shift;
  logic [c_wvw-1:0]   r_wv;
  logic [DW-1:0]      r_out_data;
  logic               r_out_push;

  logic [CW-1:0]      w_blen, w_words_next;
  logic [c_crw-1:0]   w_beats;
  logic [XAW-1:0]     w_len_bytes;
  logic               w_go, w_start, w_row_end, w_emit, w_pop;

  assign w_blen       = (r_words_left > CW'(BLEN)) ? CW'(BLEN) : r_words_left;
  assign w_beats      = c_crw'(w_blen >> c_log_wcnt);
  assign w_len_bytes  = XAW'(w_blen) * XAW'(c_bpw);
  assign w_words_next = r_words_left - w_blen;
  assign w_row_end    = (w_words_next == '0);
  assign w_start      = (r_state == S_IDLE) && load_start;
  assign w_go         = (r_state == S_ISSUE) && rmst_done &&
                        ((r_credits + w_beats) <= c_crw'(RFIFO_BEATS));

  // A new beat may enter only as the last word of the held one leaves.
  assign w_emit = (r_wv != '0) && !out_almost_full;
  assign w_pop  = rmst_user_data_available && !out_almost_full &&
                  ((r_wv == '0) || ((r_wv == c_wvw'(1)) && w_emit)) &&
                  (r_popped < r_total);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (load_start)
          w_state_nxt = ((cfg_rows == '0) || (cfg_row_words == '0)) ? S_DONE : S_ISSUE;
      S_ISSUE:
        if (w_go) w_state_nxt = S_WAIT_MST;
      S_WAIT_MST:
        // The master may still look idle on the cycle right after go.
        if (!r_skip && rmst_done)
          w_state_nxt = (r_rows_left != '0) ? S_ISSUE : S_FLUSH;
      S_FLUSH:
        if ((r_pushed == r_total) && (r_wv == '0)) w_state_nxt = S_DONE;
      S_DONE:
        w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_addr   <= '0;
      r_burst_addr <= '0;
      r_stride     <= '0;
      r_rows_left  <= '0;
      r_words_left <= '0;
      r_row_words  <= '0;
      r_total      <= '0;
      r_skip       <= 1'b0;
    end else begin
      r_skip <= w_go;
      if (w_start) begin
        r_row_addr   <= cfg_base_addr;
        r_burst_addr <= cfg_base_addr;
        r_stride     <= cfg_row_stride;
        r_rows_left  <= cfg_rows;
        r_words_left <= cfg_row_words;
        r_row_words  <= cfg_row_words;
        r_total      <= c_tw'(cfg_rows) * c_tw'(cfg_row_words);
      end else if (w_go) begin
        if (w_row_end) begin
          r_row_addr   <= r_row_addr + r_stride;
          r_burst_addr <= r_row_addr + r_stride;
          r_rows_left  <= r_rows_left - CW'(1);
          r_words_left <= r_row_words;
        end else begin
          r_burst_addr <= r_burst_addr + w_len_bytes;
          r_words_left <= w_words_next;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits  <= '0;
      r_popped   <= '0;
      r_pushed   <= '0;
      r_shift    <= '0;
      r_wv       <= '0;
      r_out_data <= '0;
      r_out_push <= 1'b0;
    end else begin
      r_credits <= r_credits + (w_go ? w_beats : '0) - (w_pop ? c_crw'(1) : '0);
      if (w_start) begin
        r_popped <= '0;
        r_pushed <= '0;
      end else begin
        if (w_pop)  r_popped <= r_popped + c_tw'(c_wcnt);
        if (w_emit) r_pushed <= r_pushed + c_tw'(1);
      end
      if (w_pop) begin
        r_shift <= rmst_user_buffer_data;
        r_wv    <= c_wvw'(c_wcnt);
      end else if (w_emit) begin
        r_shift <= r_shift >> DW;
        r_wv    <= r_wv - c_wvw'(1);
      end
      r_out_push <= w_emit;
      if (w_emit) r_out_data <= r_shift[DW-1:0];
    end
  end

  assign load_busy             = (r_state == S_ISSUE) || (r_state == S_WAIT_MST) ||
                                 (r_state == S_FLUSH);
  assign load_done             = (r_state == S_DONE);
  assign rmst_fixed_location   = 1'b0;
  assign rmst_read_base        = r_burst_addr;
  assign rmst_read_length      = w_len_bytes;
  assign rmst_go               = w_go;
  assign rmst_user_read_buffer = w_pop;
  assign out_data              = r_out_data;
  assign out_push              = r_out_push;

endmodule
`default_nettype wire

// File: tb/tb_rmst_strided_tile_loader.sv
`default_nettype none
// Bench for rmst_strided_tile_loader: a read-master/memory responder plus a
// behavioural tile model (address-ordered words, burst split list).
module tb_rmst_strided_tile_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  cfg_base_addr = '0, cfg_row_stride = '0;
  logic [15:0]  cfg_row_words = '0, cfg_rows = '0;
  logic         load_start = 1'b0;
  logic         load_busy, load_done, rmst_fixed_location, rmst_go;
  logic [31:0]  rmst_read_base, rmst_read_length;
  logic         rmst_done = 1'b1;
  logic         rmst_user_read_buffer;
  logic [127:0] rmst_user_buffer_data;
  logic         rmst_user_data_available;
  logic [31:0]  out_data;
  logic         out_push;
  logic         out_almost_full = 1'b0;

  logic         hold = 1'b0;
  int           m_n = 0;
  logic [127:0] m_head = '0;
  logic [127:0] mq[$];
  int           done_cnt = 0;

  logic [31:0]  push_q[$], exp_w[$];
  logic [63:0]  go_q[$], exp_b[$];
  int           n_done = 0, cyc = 0, done_cyc = 0, last_push_cyc = 0;
  int           checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign rmst_user_data_available = !hold && (m_n != 0);
  assign rmst_user_buffer_data    = m_head;

  rmst_strided_tile_loader dut (
    .clk(clk), .rst(rst),
    .cfg_base_addr(cfg_base_addr), .cfg_row_words(cfg_row_words),
    .cfg_rows(cfg_rows), .cfg_row_stride(cfg_row_stride),
    .load_start(load_start), .load_busy(load_busy), .load_done(load_done),
    .rmst_fixed_location(rmst_fixed_location), .rmst_read_base(rmst_read_base),
    .rmst_read_length(rmst_read_length), .rmst_go(rmst_go), .rmst_done(rmst_done),
    .rmst_user_read_buffer(rmst_user_read_buffer),
    .rmst_user_buffer_data(rmst_user_buffer_data),
    .rmst_user_data_available(rmst_user_data_available),
    .out_data(out_data), .out_push(out_push), .out_almost_full(out_almost_full)
  );

  // Memory contents: a bijective hash of the byte address.
  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [127:0] beat_at(input logic [31:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[32*i +: 32] = mw(a + 32'(4 * i));
    return b;
  endfunction

  always begin : master_model
    logic        s_go, s_rb;
    logic [31:0] s_base, s_len;
    @(negedge clk);
    s_go = rmst_go; s_rb = rmst_user_read_buffer;
    s_base = rmst_read_base; s_len = rmst_read_length;
    @(posedge clk); #1;
    if (rst) begin
      mq.delete();
      done_cnt = 0;
    end else begin
      if (s_rb && mq.size() > 0) void'(mq.pop_front());
      if (s_go) begin
        for (int k = 0; k < int'(s_len >> 4); k++) mq.push_back(beat_at(s_base + 32'(16 * k)));
        done_cnt = 2;
      end else if (done_cnt > 0) done_cnt--;
    end
    m_n       = mq.size();
    m_head    = (mq.size() > 0) ? mq[0] : '0;
    rmst_done = (done_cnt == 0);
  end

  always @(negedge clk) begin
    cyc++;
    if (out_push) begin push_q.push_back(out_data); last_push_cyc = cyc; end
    if (rmst_go) go_q.push_back({rmst_read_base, rmst_read_length});
    if (load_done) begin n_done++; done_cyc = cyc; end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {58'd0, load_busy, load_done, rmst_go, rmst_user_read_buffer,
                         out_push, rmst_fixed_location}, 64'd0);
    chk({tag, "_base"}, {32'd0, rmst_read_base}, 64'd0);
    chk({tag, "_len"},  {32'd0, rmst_read_length}, 64'd0);
    chk({tag, "_data"}, {32'd0, out_data}, 64'd0);
  endtask

  task automatic start_tile(input logic [31:0] base, input int rows, input int rw,
                            input logic [31:0] stride);
    logic [31:0] ra, a;
    int rem, b;
    exp_w.delete(); exp_b.delete(); push_q.delete(); go_q.delete(); n_done = 0;
    for (int r = 0; r < rows; r++) begin
      ra = base + 32'(r) * stride;
      for (int w = 0; w < rw; w++) exp_w.push_back(mw(ra + 32'(4 * w)));
      rem = rw; a = ra;
      while (rem > 0) begin
        b = (rem > 8) ? 8 : rem;
        exp_b.push_back({a, 32'(4 * b)});
        a += 32'(4 * b); rem -= b;
      end
    end
    @(posedge clk); #1;
    cfg_base_addr = base; cfg_rows = 16'(rows); cfg_row_words = 16'(rw);
    cfg_row_stride = stride; load_start = 1'b1;
    @(negedge clk);
    chk("busy_low_on_start", {63'd0, load_busy}, 64'd0);
    @(posedge clk); #1;
    load_start = 1'b0;
    cfg_base_addr = $urandom; cfg_rows = 16'($urandom); cfg_row_words = 16'($urandom);
    cfg_row_stride = $urandom;
    @(negedge clk);
    chk("busy_after_start", {63'd0, load_busy}, {63'd0, (rows != 0 && rw != 0)});
    chk("done_if_empty", {63'd0, load_done}, {63'd0, (rows == 0 || rw == 0)});
  endtask

  task automatic finish_tile(input bit rnd_af);
    int c = 0;
    while (n_done == 0 && c < 5000) begin
      @(posedge clk); #1;
      out_almost_full = rnd_af ? ($urandom_range(0, 3) == 0) : 1'b0;
      c++;
    end
    out_almost_full = 1'b0;
    chk("done_seen", 64'(n_done), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("done_single", 64'(n_done), 64'd1);
    chk("idle_after_done", {63'd0, load_busy}, 64'd0);
    chk("n_words", 64'(push_q.size()), 64'(exp_w.size()));
    for (int i = 0; i < push_q.size() && i < exp_w.size(); i++)
      chk($sformatf("word%0d", i), {32'd0, push_q[i]}, {32'd0, exp_w[i]});
    chk("n_bursts", 64'(go_q.size()), 64'(exp_b.size()));
    for (int i = 0; i < go_q.size() && i < exp_b.size(); i++)
      chk($sformatf("burst%0d", i), go_q[i], exp_b[i]);
    if (exp_w.size() > 0)
      chk("done_after_last_push", 64'(done_cyc - last_push_cyc), 64'd1);
  endtask

  task automatic wait_pushes(input int n);
    int c = 0;
    while (push_q.size() < n && c < 300) begin @(posedge clk); #1; c++; end
    chk("pushes_reached", {63'd0, push_q.size() >= n}, 64'd1);
  endtask

  initial begin
    int viol;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("after_reset");

    start_tile(32'h0000_1000, 1, 16, 32'h0);   finish_tile(1'b0);
    start_tile(32'h0000_0000, 3, 12, 32'h200); finish_tile(1'b0);
    start_tile(32'hFFFF_FFC0, 3, 16, 32'h40);  finish_tile(1'b1);
    for (int t = 0; t < 4; t++) begin
      start_tile($urandom & 32'hFFFF_FFF0, $urandom_range(1, 4), 4 * $urandom_range(1, 6),
                 32'(16 * $urandom_range(0, 64)));
      finish_tile(1'b1);
    end

    // Back-pressure held for five cycles in the middle of a beat.
    start_tile(32'h0000_6000, 1, 16, 32'h0);
    wait_pushes(2);
    @(posedge clk); #1;
    out_almost_full = 1'b1; viol = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rmst_user_read_buffer) viol++;
      if (k > 0 && out_push) viol++;
      if (k < 4) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    out_almost_full = 1'b0;
    @(negedge clk);
    if (out_push) viol++;
    chk("stall_quiet", 64'(viol), 64'd0);
    finish_tile(1'b0);

    // Credit throttle: no data drained, so 16 beats of credit = 8 bursts.
    hold = 1'b1;
    start_tile(32'h0000_8000, 1, 96, 32'h0);
    repeat (60) @(posedge clk);
    #1;
    chk("credit_cap_gos", 64'(go_q.size()), 64'd8);
    chk("credit_no_push", 64'(push_q.size()), 64'd0);
    hold = 1'b0;
    @(posedge clk); #1;
    hold = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("credit_one_free_gos", 64'(go_q.size()), 64'd8);
    chk("credit_one_beat_words", 64'(push_q.size()), 64'd4);
    hold = 1'b0;
    finish_tile(1'b0);

    // A start pulse while busy must not disturb the tile.
    start_tile(32'h0000_5000, 2, 20, 32'h100);
    repeat (3) @(posedge clk);
    #1;
    cfg_base_addr = 32'h0000_9990; cfg_rows = 16'd7; cfg_row_words = 16'd4;
    cfg_row_stride = 32'h10; load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    finish_tile(1'b0);

    start_tile(32'h0000_4000, 0, 8, 32'h100); finish_tile(1'b0);
    start_tile(32'h0000_4000, 2, 0, 32'h100); finish_tile(1'b0);

    // Reset in the middle of a transfer, then a fresh 1x8 tile.
    start_tile(32'h0000_2000, 2, 16, 32'h100);
    wait_pushes(1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    start_tile(32'h0000_3000, 1, 8, 32'h0);
    finish_tile(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
